// File: rtl/mu0_pkg.sv
// Shared opcodes, FSM states and ALU selects
// for the parametrised MU0 accumulator core.
package mu0_pkg;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_STO = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_JMP = 4'h4;
   localparam logic [3:0] OP_JGE = 4'h5;
   localparam logic [3:0] OP_JNE = 4'h6;
   localparam logic [3:0] OP_STP = 4'h7;
   localparam logic [3:0] OP_LDI = 4'h8;
   localparam logic [3:0] OP_AND = 4'h9;
   localparam logic [3:0] OP_OR  = 4'hA;
   localparam logic [3:0] OP_XOR = 4'hB;
   localparam logic [3:0] OP_ADI = 4'hC;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_PAUSE = 3'd4,
      S_HALT  = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      ALU_B   = 3'd0,
      ALU_ADD = 3'd1,
      ALU_SUB = 3'd2,
      ALU_AND = 3'd3,
      ALU_OR  = 3'd4,
      ALU_XOR = 3'd5
   } alu_e;

   function automatic alu_e aluSel(input logic [3:0] op);
      case (op)
         OP_ADD, OP_ADI: aluSel = ALU_ADD;
         OP_SUB:         aluSel = ALU_SUB;
         OP_AND:         aluSel = ALU_AND;
         OP_OR:          aluSel = ALU_OR;
         OP_XOR:         aluSel = ALU_XOR;
         default:        aluSel = ALU_B;
      endcase
   endfunction

endpackage

// File: rtl/mu0_if.sv
// Memory bus of the MU0 core: req/ack handshake
// with wait-state support.
interface mu0_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = DATA_W - 4
);
   logic              memReq;
   logic              memWe;
   logic [ADDR_W-1:0] memAddr;
   logic [DATA_W-1:0] memWData;
   logic [DATA_W-1:0] memRData;
   logic              memAck;

   modport master (
      output memReq, memWe, memAddr, memWData,
      input  memRData, memAck
   );

   modport slave (
      input  memReq, memWe, memAddr, memWData,
      output memRData, memAck
   );
endinterface

// File: rtl/mu0_alu.sv
// Combinational accumulator ALU; arithmetic wraps
// modulo 2^DATA_W with no flags.
module mu0_alu
   import mu0_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  alu_e              op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] y
);

   always_comb begin
      y = b;
      unique case (op)
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_XOR: y = a ^ b;
         default: y = b;
      endcase
   end

endmodule

// File: rtl/mu0_pcore.sv
// MU0 accumulator core: fetch/exec/mem FSM with
// wait-state tolerant bus and single-step debug.
module mu0_pcore
   import mu0_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter logic [DATA_W-5:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              start,
   input  logic              stepEn,
   input  logic              step,
   mu0_if.master             bus,
   output logic              done,
   output logic              err,
   output logic              paused,
   output logic [DATA_W-5:0] pc,
   output logic [DATA_W-1:0] ir,
   output logic [DATA_W-1:0] acc,
   output logic [2:0]        state
);

   localparam int ADDR_W = DATA_W - 4;

   state_e            stateQ, stateD, retire;
   logic              startQ, startRise;
   logic              opWe, weD;
   logic [ADDR_W-1:0] opAddr, addrD, pcD, opS;
   logic [DATA_W-1:0] irD, accD, aluB, aluY;
   logic              doneD, errD;
   logic [3:0]        opc;
   logic              isMem, isBad, doJmp;

   assign opc       = ir[DATA_W-1 -: 4];
   assign opS       = ir[ADDR_W-1:0];
   assign startRise = start & ~startQ;
   assign retire    = stepEn ? S_PAUSE : S_FETCH;

   assign isMem = opc inside {OP_LDA, OP_STO, OP_ADD,
                              OP_SUB, OP_AND, OP_OR,
                              OP_XOR};
   assign isBad = opc inside {4'hD, 4'hE, 4'hF};
   assign doJmp = (opc == OP_JMP)
               || (opc == OP_JGE && !acc[DATA_W-1])
               || (opc == OP_JNE && acc != '0);

   // Memory operand comes from the bus; immediates from S.
   assign aluB = (stateQ == S_MEM) ? bus.memRData
                                   : DATA_W'(opS);

   mu0_alu #(.DATA_W(DATA_W)) uAlu (
      .op (aluSel(opc)),
      .a  (acc),
      .b  (aluB),
      .y  (aluY)
   );

   // Bus outputs decode registered state only.
   always_comb begin
      bus.memReq   = (stateQ == S_FETCH)
                  || (stateQ == S_MEM);
      bus.memWe    = (stateQ == S_MEM) && opWe;
      bus.memAddr  = '0;
      bus.memWData = '0;
      if (stateQ == S_FETCH) bus.memAddr = pc;
      if (stateQ == S_MEM)   bus.memAddr = opAddr;
      if (bus.memWe)         bus.memWData = acc;
   end

   always_comb begin
      stateD = stateQ;
      pcD    = pc;
      irD    = ir;
      accD   = acc;
      doneD  = done;
      errD   = err;
      weD    = opWe;
      addrD  = opAddr;
      unique case (stateQ)
         S_IDLE, S_HALT: begin
            if (startRise) begin
               doneD  = 1'b0;
               errD   = 1'b0;
               accD   = '0;
               pcD    = RESET_PC;
               stateD = S_FETCH;
            end
         end
         S_FETCH: begin
            if (bus.memAck) begin
               irD    = bus.memRData;
               pcD    = pc + ADDR_W'(1);
               stateD = S_EXEC;
            end
         end
         S_EXEC: begin
            stateD = retire;
            unique case (1'b1)
               isMem: begin
                  stateD = S_MEM;
                  weD    = (opc == OP_STO);
                  addrD  = opS;
               end
               doJmp: pcD = opS;
               (opc == OP_LDI || opc == OP_ADI):
                  accD = aluY;
               (opc == OP_STP): begin
                  doneD  = 1'b1;
                  stateD = S_HALT;
               end
               isBad: begin
                  errD   = 1'b1;
                  stateD = S_HALT;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            if (bus.memAck) begin
               if (!opWe) accD = aluY;
               stateD = retire;
            end
         end
         S_PAUSE: begin
            if (step || !stepEn) stateD = S_FETCH;
         end
         default: stateD = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         stateQ <= S_IDLE;
         startQ <= 1'b0;
         pc     <= RESET_PC;
         ir     <= '0;
         acc    <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
         paused <= 1'b0;
         opWe   <= 1'b0;
         opAddr <= '0;
      end else begin
         stateQ <= stateD;
         startQ <= start;
         pc     <= pcD;
         ir     <= irD;
         acc    <= accD;
         done   <= doneD;
         err    <= errD;
         paused <= (stateD == S_PAUSE);
         opWe   <= weD;
         opAddr <= addrD;
      end
   end

   assign state = stateQ;

endmodule
